// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame ball stepper; steps X then Y on each vsync start,
// reflects off the active-area walls and publishes a double-buffered position.
module ball_motion_ctrl #(
  parameter int   H_ACTIVE  = 640,
  parameter int   V_ACTIVE  = 480,
  parameter int   BALL_SIZE = 16,
  parameter int   X_INIT    = 312,
  parameter int   Y_INIT    = 232,
  parameter int   SPEED_W   = 3,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               vsync,
  input  logic               pause,
  input  logic               recenter,
  input  logic [SPEED_W-1:0] speed,
  output logic [9:0]         ball_x,
  output logic [9:0]         ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               bounce,
  output logic               update_done,
  output logic               busy
);
  localparam logic [10:0] XMAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  XI   = 10'(X_INIT);
  localparam logic [9:0]  YI   = 10'(Y_INIT);

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

  state_t      state_q;
  logic        vsync_q, dir_x_q, dir_y_q, bx_q, by_q, bounce_q, done_q;
  logic [9:0]  wx_q, wy_q, ball_x_q, ball_y_q;
  logic [11:0] step_x_d, step_y_d;
  logic        tick;

  // Result packs {position, direction, bounce flag}; out-of-range positions clamp to the wall.
  function automatic logic [11:0] step_axis(input logic [9:0] p, input logic d,
                                            input logic [SPEED_W-1:0] s, input logic [10:0] m);
    logic [10:0] sum, dif;
    sum = {1'b0, p} + 11'(s);
    dif = {1'b0, p} - 11'(s);
    if (d) return (sum >= m) ? {m[9:0], 2'b01} : {sum[9:0], 2'b10};
    return ({1'b0, p} <= 11'(s)) ? {10'd0, 2'b11} : {(dif > m) ? m[9:0] : dif[9:0], 2'b00};
  endfunction

  assign tick        = (vsync == VSYNC_POL) && (vsync_q != VSYNC_POL);
  assign step_x_d    = step_axis(wx_q, dir_x_q, speed, XMAX);
  assign step_y_d    = step_axis(wy_q, dir_y_q, speed, YMAX);
  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign dir_x       = dir_x_q;
  assign dir_y       = dir_y_q;
  assign bounce      = bounce_q;
  assign update_done = done_q;
  assign busy        = state_q != IDLE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      vsync_q  <= ~VSYNC_POL;
      wx_q     <= XI;
      wy_q     <= YI;
      ball_x_q <= XI;
      ball_y_q <= YI;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      bx_q     <= 1'b0;
      by_q     <= 1'b0;
      bounce_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vsync_q  <= vsync;
      bounce_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: if (tick && !pause) begin
          if (recenter) begin
            wx_q    <= XI;
            wy_q    <= YI;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            bx_q    <= 1'b0;
            by_q    <= 1'b0;
            state_q <= COMMIT;
          end else state_q <= STEP_X;
        end
        STEP_X: begin
          {wx_q, dir_x_q, bx_q} <= step_x_d;
          state_q <= STEP_Y;
        end
        STEP_Y: begin
          {wy_q, dir_y_q, by_q} <= step_y_d;
          state_q <= COMMIT;
        end
        COMMIT: begin
          ball_x_q <= wx_q;
          ball_y_q <= wy_q;
          bounce_q <= bx_q | by_q;
          done_q   <= 1'b1;
          bx_q     <= 1'b0;
          by_q     <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: scoreboard bench; a reference model predicts each committed frame.
`timescale 1ns/1ps
module tb_ball_motion_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, vsync, pause, recenter;
  logic [2:0] speed;
  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y, bounce, update_done, busy;

  typedef struct {int x; int y; bit dx; bit dy; bit b;} exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int mx, my;
  bit mdx, mdy;

  ball_motion_ctrl dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .pause(pause), .recenter(recenter),
    .speed(speed), .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
    .bounce(bounce), .update_done(update_done), .busy(busy)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic axis(inout int p, inout bit d, input int s, input int m, output bit b);
    b = 1'b0;
    if (d) begin
      if (p + s >= m) begin p = m; d = 1'b0; b = 1'b1; end
      else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1'b1; b = 1'b1; end
      else p = p - s;
    end
  endtask

  task automatic model_reset();
    mx = 312; my = 232; mdx = 1'b1; mdy = 1'b1;
  endtask

  // One vsync frame: falling edge, then watch the pulse latency and busy length.
  task automatic frame(input int s, input bit p, input bit r);
    int lat, nbusy;
    bit bx, by;
    @(negedge clk);
    speed = 3'(s); pause = p; recenter = r; vsync = 1'b0;
    if (!p) begin
      if (r) begin model_reset(); bx = 1'b0; by = 1'b0; end
      else begin axis(mx, mdx, s, 624, bx); axis(my, mdy, s, 464, by); end
      exp_q.push_back('{mx, my, mdx, mdy, bx | by});
    end
    lat = 0; nbusy = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (update_done && lat == 0) lat = i;
      if (i == 2) vsync = 1'b1;
    end
    check("done_latency", lat, p ? 0 : (r ? 2 : 4));
    check("busy_cycles", nbusy, p ? 0 : (r ? 1 : 3));
    check("hold_x", ball_x, mx);
    check("hold_y", ball_y, my);
    check("hold_dirs", {dir_x, dir_y}, {mdx, mdy});
  endtask

  always @(negedge clk) begin
    if (reset_n && update_done === 1'b1) begin
      check("done_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_x", ball_x, e.x);
        check("sb_y", ball_y, e.y);
        check("sb_dir_x", dir_x, e.dx);
        check("sb_dir_y", dir_y, e.dy);
        check("sb_bounce", bounce, e.b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; vsync = 1'b1; pause = 1'b0; recenter = 1'b0; speed = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_x", ball_x, 312);
    check("rst_y", ball_y, 232);
    check("rst_dirs", {dir_x, dir_y}, 2'b11);
    check("rst_pulses", {bounce, update_done, busy}, 3'b000);
    reset_n = 1'b1;
    frame(2, 0, 0);
    repeat (44) frame(7, 0, 0);
    check("x_near_wall", ball_x, 622);
    frame(4, 0, 0);
    frame(4, 0, 0);
    frame(0, 0, 0);
    repeat (5) frame(3, 1, 0);
    frame(3, 0, 0);
    frame(5, 0, 1);
    repeat (150) frame($urandom_range(0, 7), $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    @(negedge clk);
    speed = 3'd3; pause = 1'b0; recenter = 1'b0; vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_abort", busy, 1);
    reset_n = 1'b0; vsync = 1'b1;
    #1;
    check("abort_x", ball_x, 312);
    check("abort_y", ball_y, 232);
    check("abort_dirs", {dir_x, dir_y}, 2'b11);
    check("abort_pulses", {bounce, update_done, busy}, 3'b000);
    model_reset();
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) frame($urandom_range(0, 7), $urandom_range(0, 9) == 0, 1'b0);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
